clock_display_mux: RTL and testbench

CLOCK_DISPLAY_MUX -- requirements
Module: clock_display_mux

---
 rtl/clock_display_mux_pkg.sv | 66 ++++++
 rtl/clock_display_mux_if.sv | 12 +
 rtl/clock_display_mux_seg7_decode.sv | 24 ++
 rtl/clock_display_mux.sv | 138 +++++++++++++
 tb/tb_clock_display_mux.sv | 202 ++++++++++++++++++++
 5 files changed

// File: rtl/clock_display_mux_pkg.sv
// Shared types and constants for the six-digit HH:MM:SS display multiplexer.
// Holds the active-low seven-segment patterns (bit 0 = a .. bit 6 = g), the
// DASH/BLANK patterns, the digit count, the scan FSM encoding, and a
// compare-subtract helper that splits a 0..63 value into tens/units.
package clock_display_mux_pkg;

  localparam int unsigned NUM_DIGITS = 6;
  localparam int unsigned CNT_W      = 16;

  localparam logic [6:0] DASH  = 7'h3F;
  localparam logic [6:0] BLANK = 7'h7F;

  // Index n holds the pattern for decimal digit n.
  localparam logic [9:0][6:0] SEG_DIGITS = {
    7'h10, 7'h00, 7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
  };

  typedef enum logic {
    SLOT_ON  = 1'b0,
    SLOT_GAP = 1'b1
  } state_t;

  typedef struct packed {
    logic [4:0] hrs;
    logic [5:0] min;
    logic [5:0] sec;
  } time_t;

  typedef struct packed {
    logic [3:0] tens;
    logic [3:0] units;
  } bcd_t;

  // Converted display content; dig[5] is hours tens, dig[0] seconds units.
  typedef struct packed {
    logic [NUM_DIGITS-1:0][3:0] dig;
    logic [2:0]                 dash;      // [2]=hrs [1]=min [0]=sec
    logic                       hrs_blank; // valid hours with zero tens
    logic                       colon_on;  // even seconds
  } disp_t;

  // Compare-subtract chain: no divider, tens saturates at 5.
  function automatic bcd_t bcd_split(input logic [5:0] v);
    bcd_t r;
    r.tens  = 4'd0;
    r.units = v[3:0];
    if (v >= 6'd50) begin
      r.tens  = 4'd5;
      r.units = 4'(v - 6'd50);
    end else if (v >= 6'd40) begin
      r.tens  = 4'd4;
      r.units = 4'(v - 6'd40);
    end else if (v >= 6'd30) begin
      r.tens  = 4'd3;
      r.units = 4'(v - 6'd30);
    end else if (v >= 6'd20) begin
      r.tens  = 4'd2;
      r.units = 4'(v - 6'd20);
    end else if (v >= 6'd10) begin
      r.tens  = 4'd1;
      r.units = 4'(v - 6'd10);
    end
    return r;
  endfunction

endpackage

// File: rtl/clock_display_mux_if.sv
// Time-update bus into the display multiplexer.
//   time_vld : one-cycle strobe, hrs/min/sec valid in the same cycle
//   hrs/min/sec : binary time fields
interface clock_display_mux_if;
  logic       time_vld;
  logic [4:0] hrs;
  logic [5:0] min;
  logic [5:0] sec;

  modport master (output time_vld, hrs, min, sec);
  modport slave  (input  time_vld, hrs, min, sec);
endinterface

// File: rtl/clock_display_mux_seg7_decode.sv
// Combinational digit-to-segment decoder (active-low, bit 6 = g).
//   digit_i : 0..9 digit value
//   blank_i : force all segments off
//   dash_i  : show segment g only (takes priority over blank)
//   seg_c   : segment pattern
module seg7_decode
  import clock_display_mux_pkg::*;
(
  input  logic [3:0] digit_i,
  input  logic       blank_i,
  input  logic       dash_i,
  output logic [6:0] seg_c
);

  always_comb begin
    seg_c = BLANK;
    if (dash_i) begin
      seg_c = DASH;
    end else if (!blank_i && (digit_i <= 4'd9)) begin
      seg_c = SEG_DIGITS[digit_i];
    end
  end

endmodule

// File: rtl/clock_display_mux.sv
// Six-digit multiplexed HH:MM:SS seven-segment driver.
//   clk, rstn : clock, asynchronous active-low reset
//   tbus      : time update bus (slave)
//   an        : active-low anodes, bit 5 = hours tens, bit 0 = seconds units
//   seg, dp   : active-low segments a..g and colon point, registered
// Each digit slot is REFRESH_DIV cycles: anode on, then GAP_CYCLES all-off.
module clock_display_mux
  import clock_display_mux_pkg::*;
#(
  parameter int unsigned REFRESH_DIV = 1000,
  parameter int unsigned GAP_CYCLES  = 1
) (
  input  logic                  clk,
  input  logic                  rstn,
  clock_display_mux_if.slave    tbus,
  output logic [NUM_DIGITS-1:0] an,
  output logic [6:0]            seg,
  output logic                  dp
);

  localparam logic [CNT_W-1:0]      ON_LAST  = CNT_W'(REFRESH_DIV - GAP_CYCLES - 1);
  localparam logic [CNT_W-1:0]      GAP_LAST = CNT_W'(GAP_CYCLES - 1);
  localparam logic [NUM_DIGITS-1:0] AN_OFF   = {NUM_DIGITS{1'b1}};
  localparam logic [2:0]            IDX_TOP  = 3'(NUM_DIGITS - 1);
  // Conversion of the all-zero reset snapshot.
  localparam disp_t DISP_RST = '{dig: '0, dash: 3'b000, hrs_blank: 1'b1, colon_on: 1'b1};

  time_t                 snap_q;
  disp_t                 disp_d, disp_q;
  bcd_t                  hs, ms, ss;
  state_t                state_q;
  logic [2:0]            idx_q, idx_nxt;
  logic [CNT_W-1:0]      cnt_q;
  logic                  first_q;
  logic [NUM_DIGITS-1:0] an_q;
  logic [6:0]            seg_q, seg_c;
  logic                  dp_q, dp_nxt;
  logic [3:0]            dig_sel;
  logic                  blank_sel, dash_sel;

  // Snapshot capture; the display never looks at the live bus.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      snap_q <= '0;
    end else if (tbus.time_vld) begin
      snap_q <= {tbus.hrs, tbus.min, tbus.sec};
    end
  end

  // Range check and tens/units split of the snapshot.
  always_comb begin
    hs               = bcd_split({1'b0, snap_q.hrs});
    ms               = bcd_split(snap_q.min);
    ss               = bcd_split(snap_q.sec);
    disp_d           = '0;
    disp_d.dig       = {hs.tens, hs.units, ms.tens, ms.units, ss.tens, ss.units};
    disp_d.dash      = {snap_q.hrs > 5'd23, snap_q.min > 6'd59, snap_q.sec > 6'd59};
    disp_d.hrs_blank = (snap_q.hrs <= 5'd23) && (hs.tens == 4'd0);
    disp_d.colon_on  = ~snap_q.sec[0];
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      disp_q <= DISP_RST;
    end else begin
      disp_q <= disp_d;
    end
  end

  // Digit for the upcoming slot; the first slot after reset keeps digit 5.
  always_comb begin
    idx_nxt = idx_q;
    if (!first_q) begin
      idx_nxt = (idx_q == 3'd0) ? IDX_TOP : idx_q - 3'd1;
    end
    dig_sel   = disp_q.dig[idx_nxt];
    dash_sel  = disp_q.dash[idx_nxt[2:1]];
    blank_sel = (idx_nxt == IDX_TOP) && disp_q.hrs_blank;
    dp_nxt    = ~(disp_q.colon_on && ((idx_nxt == 3'd4) || (idx_nxt == 3'd2)));
  end

  seg7_decode u_dec (
    .digit_i (dig_sel),
    .blank_i (blank_sel),
    .dash_i  (dash_sel),
    .seg_c   (seg_c)
  );

  // Scan FSM; seg/dp are latched only on slot entry so mid-slot updates wait.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= SLOT_GAP;
      idx_q   <= IDX_TOP;
      cnt_q   <= '0;
      first_q <= 1'b1;
      an_q    <= AN_OFF;
      seg_q   <= BLANK;
      dp_q    <= 1'b1;
    end else begin
      case (state_q)
        SLOT_ON: begin
          if (cnt_q == ON_LAST) begin
            state_q <= SLOT_GAP;
            cnt_q   <= '0;
            an_q    <= AN_OFF;
            seg_q   <= BLANK;
            dp_q    <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        SLOT_GAP: begin
          if (cnt_q == GAP_LAST) begin
            state_q <= SLOT_ON;
            cnt_q   <= '0;
            idx_q   <= idx_nxt;
            first_q <= 1'b0;
            an_q    <= ~(NUM_DIGITS'(1) << idx_nxt);
            seg_q   <= seg_c;
            dp_q    <= dp_nxt;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: begin
          state_q <= SLOT_GAP;
          cnt_q   <= '0;
          an_q    <= AN_OFF;
        end
      endcase
    end
  end

  assign an  = an_q;
  assign seg = seg_q;
  assign dp  = dp_q;

endmodule

// File: tb/tb_clock_display_mux.sv
// Self-checking bench for clock_display_mux with REFRESH_DIV=4, GAP_CYCLES=1.
// The reference derives the anode from the cycle count since reset and the
// digit patterns from the time value with plain division/modulo.
module tb_clock_display_mux;

  localparam int RD  = 4;
  localparam int GAP = 1;
  localparam int ON  = RD - GAP;

  logic       clk = 1'b0;
  logic       rstn;
  logic [5:0] an;
  logic [6:0] seg;
  logic       dp;

  clock_display_mux_if tbus ();

  clock_display_mux #(.REFRESH_DIV(RD), .GAP_CYCLES(GAP)) dut (
    .clk  (clk),
    .rstn (rstn),
    .tbus (tbus),
    .an   (an),
    .seg  (seg),
    .dp   (dp)
  );

  always #5 clk = ~clk;

  typedef struct {int h; int m; int s;} tv_t;

  int         total = 0;
  int         bad   = 0;
  int         kcyc  = 0;
  tv_t        snap, hist1, hist2, shown;
  logic [5:0] prev_an;
  logic [6:0] pat [10];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, kcyc);
    end
  endtask

  function automatic int cur_phase();
    return (kcyc - 1) % RD;
  endfunction

  function automatic int cur_digit();
    return 5 - (((kcyc - 1) / RD) % 6);
  endfunction

  function automatic logic [6:0] exp_seg(input tv_t t, input int d);
    int v, lim, dg;
    v   = (d >= 4) ? t.h : (d >= 2) ? t.m : t.s;
    lim = (d >= 4) ? 23 : 59;
    if (v > lim) return 7'h3F;
    dg = (d % 2 == 1) ? v / 10 : v % 10;
    if (d == 5 && dg == 0) return 7'h7F;
    return pat[dg];
  endfunction

  function automatic logic exp_dp(input tv_t t, input int d);
    if ((d == 4 || d == 2) && (t.s % 2 == 0)) return 1'b0;
    return 1'b1;
  endfunction

  task automatic clear_model();
    kcyc    = 0;
    snap    = '{0, 0, 0};
    hist1   = snap;
    hist2   = snap;
    shown   = snap;
    prev_an = 6'h3F;
  endtask

  task automatic check_outputs();
    int         p, d;
    logic [5:0] exp_an;
    p = cur_phase();
    d = cur_digit();
    exp_an = (p < ON) ? (6'h3F ^ (6'(1) << d)) : 6'h3F;
    chk("an", 32'(an), 32'(exp_an));
    if (p < ON) begin
      chk($sformatf("seg_d%0d", d), 32'(seg), 32'(exp_seg(shown, d)));
      chk($sformatf("dp_d%0d", d), 32'(dp), 32'(exp_dp(shown, d)));
    end
    chk("an_onehot", 32'($countones(~an) <= 1), 32'(1));
    if (an != prev_an && an != 6'h3F) chk("gap_before_an", 32'(prev_an), 32'h3F);
    prev_an = an;
  endtask

  // One clock: drive inputs, advance the model past the edge, check.
  task automatic tick(input bit vld, input logic [4:0] h, input logic [5:0] m, input logic [5:0] s);
    tbus.time_vld = vld;
    tbus.hrs      = h;
    tbus.min      = m;
    tbus.sec      = s;
    @(posedge clk);
    #1;
    kcyc++;
    // A slot shows the snapshot held two edges earlier (capture + convert).
    if (cur_phase() == 0) shown = hist2;
    hist2 = hist1;
    if (vld) snap = '{int'(h), int'(m), int'(s)};
    hist1 = snap;
    check_outputs();
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick(1'b0, 5'd0, 6'd0, 6'd0);
  endtask

  task automatic wait_slot(input int d, input int p);
    bit found;
    found = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (kcyc > 0 && cur_digit() == d && cur_phase() == p) begin
        found = 1'b1;
        break;
      end
      tick(1'b0, 5'd0, 6'd0, 6'd0);
    end
    chk("wait_slot_timeout", 32'(found), 32'(1));
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_an"}, 32'(an), 32'h3F);
    chk({tag, "_seg"}, 32'(seg), 32'h7F);
    chk({tag, "_dp"}, 32'(dp), 32'(1));
  endtask

  initial begin
    pat = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
    rstn          = 1'b0;
    tbus.time_vld = 1'b0;
    tbus.hrs      = '0;
    tbus.min      = '0;
    tbus.sec      = '0;
    clear_model();

    // Reset values, then idle scan showing blank 0:00:00.
    repeat (2) @(posedge clk);
    #1;
    chk_reset_outputs("reset");
    rstn = 1'b1;
    run(2 * 6 * RD);

    // 13:07:42
    tick(1'b1, 5'd13, 6'd7, 6'd42);
    run(2 * 6 * RD);

    // Out-of-range hours and seconds.
    tick(1'b1, 5'd25, 6'd59, 6'd60);
    run(2 * 6 * RD);

    // Update arriving mid-slot on digit 3.
    wait_slot(3, 1);
    tick(1'b1, 5'd9, 6'd30, 6'd15);
    run(2 * 6 * RD);

    // Back-to-back strobes, last wins.
    tick(1'b1, 5'd1, 6'd2, 6'd3);
    tick(1'b1, 5'd22, 6'd45, 6'd58);
    run(2 * 6 * RD);

    // Reset pulsed during an ON slot acts without a clock edge.
    wait_slot(2, 1);
    rstn = 1'b0;
    #1;
    chk_reset_outputs("async_rst");
    @(posedge clk);
    #1;
    chk_reset_outputs("held_rst");
    clear_model();
    rstn = 1'b1;
    run(2 * 6 * RD);

    // Random strobes and values, including out-of-range fields.
    for (int i = 0; i < 10000; i++) begin
      bit         v;
      logic [4:0] h;
      logic [5:0] m, s;
      v = ($urandom_range(7) == 0);
      if ($urandom_range(3) == 0) begin
        h = 5'($urandom_range(31));
        m = 6'($urandom_range(63));
        s = 6'($urandom_range(63));
      end else begin
        h = 5'($urandom_range(23));
        m = 6'($urandom_range(59));
        s = 6'($urandom_range(59));
      end
      tick(v, h, m, s);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
